// File: rtl/fp_accum_seq.sv
// fp_accum_seq: sequences a stream of FP32 terms through a shared FP adder,
// accumulating acc = acc + term. The final sum is returned with a one-cycle
// done pulse. This block does no FP arithmetic itself.
//
// Handshakes:
//   Input stream: in_data is transferred on a rising edge where both in_valid
//   and in_ready are high. in_ready depends only on state, never on in_valid.
//   Adder request: add_start is a single-cycle pulse. It is raised only when the
//   adder is neither busy nor presenting a result. add_a/add_b are held from
//   that pulse until add_ready returns. add_ready is the result-valid strobe,
//   and it is honoured only while a request is outstanding.
module fp_accum_seq #(
    parameter int CNT_W     = 8,
    parameter int DRAIN_CYC = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [CNT_W-1:0] num_terms,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             add_start,
    output logic             add_op,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic             add_ready,
    input  logic             add_busy,
    input  logic [31:0]      add_y,
    output logic [31:0]      sum,
    output logic             done,
    output logic             busy,
    output logic             inf_nan
);

    localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_IN  = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_ADD = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   terms_q, terms_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        sum_q, sum_d;
    logic               inf_q, inf_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    logic               go_ok;
    logic [CNT_W-1:0]   cnt_inc;

    // A run may only start once the post-reset drain window has elapsed, so a
    // result still in flight from an abandoned run cannot be mistaken for ours.
    assign go_ok   = go && (drain_q == '0);
    assign cnt_inc = cnt_q + CNT_W'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (go_ok) begin
                    state_d = (num_terms == '0) ? S_DONE : S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!add_busy && !add_ready) begin
                    state_d = S_WAIT_ADD;
                end
            end
            S_WAIT_ADD: begin
                if (add_ready) begin
                    state_d = (cnt_inc == terms_q) ? S_DONE : S_WAIT_IN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore-style outputs plus the add_start qualifier on adder availability.
    always_comb begin
        in_ready  = (state_q == S_WAIT_IN);
        add_start = (state_q == S_ISSUE) && !add_busy && !add_ready;
        done      = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        add_op    = 1'b0;
        add_a     = a_q;
        add_b     = b_q;
        sum       = sum_q;
        inf_nan   = inf_q;
    end

    // Datapath next-state: accumulator, counters, operand and result registers.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        terms_d = terms_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        inf_d   = inf_q;
        drain_d = drain_q;

        if ((state_q == S_IDLE) && (drain_q != '0)) begin
            drain_d = drain_q - DRAIN_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (go_ok) begin
                    acc_d   = 32'h0000_0000;
                    cnt_d   = '0;
                    inf_d   = 1'b0;
                    terms_d = num_terms;
                end
            end
            S_WAIT_IN: begin
                // Operands are frozen here and stay put until the next term.
                if (in_valid) begin
                    a_d = acc_q;
                    b_d = in_data;
                end
            end
            S_WAIT_ADD: begin
                if (add_ready) begin
                    acc_d = add_y;
                    cnt_d = cnt_inc;
                    inf_d = inf_q | (add_y[30:23] == 8'hFF);
                end
            end
            default: begin
            end
        endcase

        // Load sum on entry to DONE so it is already valid during the done pulse.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            sum_d = acc_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= 32'h0000_0000;
            cnt_q   <= '0;
            terms_q <= '0;
            a_q     <= 32'h0000_0000;
            b_q     <= 32'h0000_0000;
            sum_q   <= 32'h0000_0000;
            inf_q   <= 1'b0;
            drain_q <= DRAIN_W'(DRAIN_CYC);
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            terms_q <= terms_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            inf_q   <= inf_d;
            drain_q <= drain_d;
        end
    end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Bench for fp_accum_seq. A behavioural FP adder with random latency answers the
// adder requests. Expected sums come from plain real arithmetic over the term list.
module tb_fp_accum_seq;

  localparam int CNT_W     = 8;
  localparam int DRAIN_CYC = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic             go = 1'b0;
  logic [CNT_W-1:0] num_terms = '0;
  logic [31:0]      in_data = 32'h0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             add_start;
  logic             add_op;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic             add_ready = 1'b0;
  logic             add_busy = 1'b0;
  logic [31:0]      add_y = 32'h0;
  logic [31:0]      sum;
  logic             done;
  logic             busy;
  logic             inf_nan;

  fp_accum_seq #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .num_terms (num_terms),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .add_start (add_start),
    .add_op    (add_op),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ready (add_ready),
    .add_busy  (add_busy),
    .add_y     (add_y),
    .sum       (sum),
    .done      (done),
    .busy      (busy),
    .inf_nan   (inf_nan)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          done_cnt  = 0;
  int          start_cnt = 0;
  int          rst_epoch = 0;
  logic [31:0] exp_q[$];
  logic        exp_inf_q[$];
  logic [31:0] term_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- FP32 helpers (exact for the values used here) ----------------
  function automatic real fp2r(input logic [31:0] f);
    int  e;
    real m;
    e = int'(f[30:23]);
    if (e == 0) return 0.0;
    m = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    real         a;
    int          e;
    int          mant;
    logic        s;
    logic [7:0]  ee;
    logic [22:0] mm;
    if (r == 0.0) return 32'h0000_0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    mant = $rtoi((a - 1.0) * 8388608.0);
    ee = 8'(e + 127);
    mm = 23'(mant);
    return {s, ee, mm};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    return r2fp(fp2r(a) + fp2r(b));
  endfunction

  // A reset edge invalidates any operand-stability tracking in flight.
  always @(negedge rst_n) rst_epoch++;

  // ---------------- done monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && done === 1'b1) done_cnt++;
    end
  end

  // ---------------- behavioural adder ----------------
  initial begin
    logic [31:0] cap_a, cap_b;
    int          ep, lat;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && add_start === 1'b1) begin
        cap_a = add_a;
        cap_b = add_b;
        ep    = rst_epoch;
        start_cnt++;
        check("add_op", {31'b0, add_op}, 32'h0);
        @(posedge clk);
        #1 add_busy = 1'b1;
        lat = $urandom_range(1, 6);
        repeat (lat) begin
          @(negedge clk);
          if (ep == rst_epoch && rst_n === 1'b1) begin
            check("add_a_stable", add_a, cap_a);
            check("add_b_stable", add_b, cap_b);
          end
        end
        add_y     = fp_add(cap_a, cap_b);
        add_ready = 1'b1;
        add_busy  = 1'b0;
        @(negedge clk);
        add_ready = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Feeds one term; returns once it has been transferred (or the bound expires).
  task automatic send_term(input logic [31:0] t, input int gap_min, input int gap_max);
    int waited;
    repeat ($urandom_range(gap_min, gap_max)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = t;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) check("in_ready_timeout", 32'(waited), 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Runs a full accumulation over term_q[0..n-1] and scores it.
  task automatic do_run(input string tag, input int n, input int gap_min, input int gap_max,
                        input bit poke_go);
    int          d0, s0, waited;
    real         rsum;
    logic        rinf;
    logic [31:0] t, exp_sum;
    logic        exp_inf;
    rsum = 0.0;
    rinf = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = term_q[i];
      if (t[30:23] == 8'hFF) rinf = 1'b1;
      else rsum = rsum + fp2r(t);
    end
    exp_q.push_back(rinf ? 32'h7F80_0000 : r2fp(rsum));
    exp_inf_q.push_back(rinf);

    @(negedge clk);
    d0 = done_cnt;
    s0 = start_cnt;
    go = 1'b1;
    num_terms = CNT_W'(n);
    @(negedge clk);
    go = 1'b0;
    if (poke_go) begin
      go = 1'b1;
      num_terms = '0;
      @(negedge clk);
      go = 1'b0;
    end
    for (int i = 0; i < n; i++) send_term(term_q[i], gap_min, gap_max);

    waited = 0;
    while (done !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    exp_sum = exp_q.pop_front();
    exp_inf = exp_inf_q.pop_front();
    check({tag, "_done_seen"}, {31'b0, done}, 32'h1);
    if (n == 0) check({tag, "_empty_latency_le1"}, {31'b0, (waited <= 1)}, 32'h1);
    check({tag, "_sum_at_done"}, sum, exp_sum);
    check({tag, "_busy_at_done"}, {31'b0, busy}, 32'h1);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {31'b0, done}, 32'h0);
    check({tag, "_busy_after"}, {31'b0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    check({tag, "_done_count"}, 32'(done_cnt - d0), 32'h1);
    check({tag, "_start_count"}, 32'(start_cnt - s0), 32'(n));
    check({tag, "_sum_held"}, sum, exp_sum);
    check({tag, "_inf_nan"}, {31'b0, inf_nan}, {31'b0, exp_inf});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int d0, waited, n;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h0);
    check("rst_add_start", {31'b0, add_start}, 32'h0);
    check("rst_sum", sum, 32'h0);
    check("rst_inf_nan", {31'b0, inf_nan}, 32'h0);
    check("rst_add_a", add_a, 32'h0);
    rst_n = 1'b1;
    repeat (DRAIN_CYC + 2) @(negedge clk);

    // 1: four terms back-to-back.
    term_q = {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    do_run("t1", 4, 0, 0, 1'b0);
    check("t1_sum_const", sum, 32'h4120_0000);

    // 2: empty run.
    term_q = {};
    do_run("t2", 0, 0, 0, 1'b0);
    check("t2_sum_const", sum, 32'h0);

    // 3: gapped input, operand stability checked by the adder model.
    term_q = {32'h3F00_0000, 32'h3E80_0000, 32'h3E80_0000};
    do_run("t3", 3, 5, 5, 1'b0);
    check("t3_sum_const", sum, 32'h3F80_0000);

    // 4: infinity propagates and sets the sticky flag.
    term_q = {32'h7F80_0000, 32'h3F80_0000};
    do_run("t4", 2, 0, 1, 1'b0);
    check("t4_inf_const", {31'b0, inf_nan}, 32'h1);

    // 5: reset while an addition is outstanding.
    @(negedge clk);
    d0 = done_cnt;
    go = 1'b1;
    num_terms = CNT_W'(2);
    @(negedge clk);
    go = 1'b0;
    send_term(32'h4000_0000, 0, 0);
    waited = 0;
    while (add_busy !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("t5_reached_wait_add", {31'b0, add_busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", {31'b0, busy}, 32'h0);
    check("t5_rst_done", {31'b0, done}, 32'h0);
    check("t5_rst_sum", sum, 32'h0);
    check("t5_rst_add_a", add_a, 32'h0);
    check("t5_rst_add_b", add_b, 32'h0);
    check("t5_rst_add_start", {31'b0, add_start}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    go = 1'b1;
    repeat (DRAIN_CYC) @(negedge clk);
    check("t5_go_ignored_in_drain", {31'b0, busy}, 32'h0);
    go = 1'b0;
    check("t5_no_done_after_abort", 32'(done_cnt - d0), 32'h0);
    term_q = {32'h4000_0000, 32'h4000_0000};
    do_run("t5", 2, 0, 2, 1'b0);
    check("t5_sum_const", sum, 32'h4080_0000);

    // 6: go pulsed while busy must not disturb the run.
    term_q = {32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000};
    do_run("t6", 3, 1, 3, 1'b1);
    check("t6_sum_const", sum, 32'h4080_0000);

    // Random runs over exactly representable quarter-step values.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 10);
      term_q = {};
      for (int i = 0; i < n; i++) begin
        int k;
        k = $urandom_range(0, 63);
        term_q.push_back(r2fp(real'(k) / 4.0));
      end
      do_run("rnd", n, 0, 3, ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
